// File: rtl/naneye_tx_pkg.sv
// Shared types and word-format constants for the NanEye 2D serial transmitter.
package naneye_tx_pkg;

   // Link state: idle, frame-sync violation, line-sync zeros, pixel word.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FSYNC = 2'd1,
      ST_LSYNC = 2'd2,
      ST_WORD  = 2'd3
   } state_t;

   // 12-bit word: start bit, 10 data bits MSB first, stop bit.
   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT  = 1'b0;
   localparam int   WORD_BITS = 12;
   localparam int   DATA_BITS = 10;

   // Manchester mapping: a '1' is sent as 1,0 and a '0' as 0,1.
   function automatic logic manchester_half(input logic bit_val, input logic second_half);
      return bit_val ^ second_half;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/naneye_tx_tick.sv
// Half-bit tick generator: down-counter that reloads HALF_BIT_DIV-1 and
// ticks on zero. Held at reload while cleared so the first half-bit after
// a start lasts a full HALF_BIT_DIV cycles.
module naneye_tx_tick #(
   parameter int HALF_BIT_DIV = 1
) (
   input  logic CLOCK,
   input  logic RESET_N,
   input  logic i_clear,
   output logic o_tick
);

   localparam int             DW     = (HALF_BIT_DIV > 1) ? $clog2(HALF_BIT_DIV) : 1;
   localparam logic [DW-1:0]  RELOAD = DW'(HALF_BIT_DIV - 1);

   logic [DW-1:0] r_cnt;

   // Count down one half-bit period, restarting on clear or on reaching zero.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cnt <= '0;
      end else if (i_clear || (r_cnt == '0)) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/naneye_tx_encoder.sv
// NanEye 2D link transmitter: wraps 10-bit pixels in 12-bit words,
// Manchester-encodes them and inserts frame-sync / line-sync sequences.
// The position registers describe the half-bit currently on SER_OUT; on
// each tick the next half-bit is computed and registered.
module naneye_tx_encoder #(
   parameter int ROWS         = 250,
   parameter int COLS         = 250,
   parameter int HALF_BIT_DIV = 1,
   parameter int FSYNC_BITS   = 24,
   parameter int LSYNC_BITS   = 3
) (
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       ENABLE,
   input  logic [9:0] PIX_DATA,
   input  logic       PIX_VALID,
   output logic       PIX_READY,
   output logic       SER_OUT,
   output logic       SER_OUT_EN,
   output logic       FRAME_START,
   output logic       LINE_START,
   output logic       UNDERRUN,
   output logic       BUSY
);

   import naneye_tx_pkg::*;

   localparam int SYNC_MAX = max_int(FSYNC_BITS, LSYNC_BITS);
   localparam int CW       = (COLS > 1)     ? $clog2(COLS)     : 1;
   localparam int RW       = (ROWS > 1)     ? $clog2(ROWS)     : 1;
   localparam int SW       = (SYNC_MAX > 1) ? $clog2(SYNC_MAX) : 1;

   localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [SW-1:0] FSYNC_LAST = SW'(FSYNC_BITS - 1);
   localparam logic [SW-1:0] LSYNC_LAST = SW'(LSYNC_BITS - 1);
   localparam logic [3:0]    BIT_STOP   = 4'(WORD_BITS - 1);
   localparam logic [3:0]    BIT_DLAST  = 4'(WORD_BITS - 2);

   state_t          r_state,       w_state_nxt;
   logic            r_half,        w_half_nxt;
   logic [3:0]      r_bit,         w_bit_nxt;
   logic [SW-1:0]   r_sync,        w_sync_nxt;
   logic [CW-1:0]   r_col,         w_col_nxt;
   logic [RW-1:0]   r_row,         w_row_nxt;
   logic            r_cur_bit,     w_cur_bit_nxt;
   logic            r_ser_out,     w_ser_out_nxt;
   logic            r_frame_start, w_frame_start_nxt;
   logic            r_line_start,  w_line_start_nxt;
   logic            r_pix_ready,   w_pix_ready_nxt;
   logic [DATA_BITS-1:0] r_shift;

   logic w_tick;
   logic w_shift_step;
   logic w_go_fsync;
   logic w_go_lsync;
   logic w_go_word;
   logic w_go_idle;

   naneye_tx_tick #(
      .HALF_BIT_DIV (HALF_BIT_DIV)
   ) u_tick (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .i_clear (r_state == ST_IDLE),
      .o_tick  (w_tick)
   );

   // Next-state: advance one half-bit per tick, then apply entry actions.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a variable unassigned, which would infer a latch.
      w_state_nxt       = r_state;
      w_half_nxt        = r_half;
      w_bit_nxt         = r_bit;
      w_sync_nxt        = r_sync;
      w_col_nxt         = r_col;
      w_row_nxt         = r_row;
      w_cur_bit_nxt     = r_cur_bit;
      w_ser_out_nxt     = r_ser_out;
      w_frame_start_nxt = 1'b0;
      w_line_start_nxt  = 1'b0;
      w_pix_ready_nxt   = 1'b0;
      w_shift_step      = 1'b0;
      w_go_fsync        = 1'b0;
      w_go_lsync        = 1'b0;
      w_go_word         = 1'b0;
      w_go_idle         = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            w_go_fsync = ENABLE;
         end
         ST_FSYNC: begin
            if (w_tick) begin
               if (!r_half) begin
                  // Frame sync is a deliberate violation: the line stays high.
                  w_half_nxt    = 1'b1;
                  w_ser_out_nxt = 1'b1;
               end else if (r_sync == FSYNC_LAST) begin
                  w_go_lsync = 1'b1;
               end else begin
                  w_sync_nxt    = r_sync + 1'b1;
                  w_half_nxt    = 1'b0;
                  w_ser_out_nxt = 1'b1;
               end
            end
         end
         ST_LSYNC: begin
            if (w_tick) begin
               if (!r_half) begin
                  w_half_nxt    = 1'b1;
                  w_ser_out_nxt = manchester_half(1'b0, 1'b1);
               end else if (r_sync == LSYNC_LAST) begin
                  w_go_word = 1'b1;
               end else begin
                  w_sync_nxt    = r_sync + 1'b1;
                  w_half_nxt    = 1'b0;
                  w_ser_out_nxt = manchester_half(1'b0, 1'b0);
               end
            end
         end
         ST_WORD: begin
            if (w_tick) begin
               if (!r_half) begin
                  w_half_nxt    = 1'b1;
                  w_ser_out_nxt = manchester_half(r_cur_bit, 1'b1);
               end else if (r_bit != BIT_STOP) begin
                  w_bit_nxt  = r_bit + 4'd1;
                  w_half_nxt = 1'b0;
                  if (r_bit == BIT_DLAST) begin
                     w_cur_bit_nxt = STOP_BIT;
                  end else begin
                     w_cur_bit_nxt = r_shift[DATA_BITS-1];
                     w_shift_step  = 1'b1;
                  end
                  w_ser_out_nxt = manchester_half(w_cur_bit_nxt, 1'b0);
               end else if (r_col != COL_LAST) begin
                  w_col_nxt = r_col + 1'b1;
                  w_go_word = 1'b1;
               end else begin
                  w_col_nxt = '0;
                  if (r_row != ROW_LAST) begin
                     w_row_nxt  = r_row + 1'b1;
                     w_go_lsync = 1'b1;
                  end else begin
                     // Last word of the frame: chain straight into the next
                     // frame sync with no gap, or stop if disabled.
                     w_row_nxt  = '0;
                     w_go_fsync = ENABLE;
                     w_go_idle  = !ENABLE;
                  end
               end
            end
         end
      endcase

      if (w_go_fsync) begin
         w_state_nxt       = ST_FSYNC;
         w_half_nxt        = 1'b0;
         w_sync_nxt        = '0;
         w_ser_out_nxt     = 1'b1;
         w_frame_start_nxt = 1'b1;
      end
      if (w_go_lsync) begin
         w_state_nxt      = ST_LSYNC;
         w_half_nxt       = 1'b0;
         w_sync_nxt       = '0;
         w_ser_out_nxt    = manchester_half(1'b0, 1'b0);
         w_line_start_nxt = 1'b1;
      end
      if (w_go_word) begin
         w_state_nxt     = ST_WORD;
         w_half_nxt      = 1'b0;
         w_sync_nxt      = '0;
         w_bit_nxt       = 4'd0;
         w_cur_bit_nxt   = START_BIT;
         w_ser_out_nxt   = manchester_half(START_BIT, 1'b0);
         w_pix_ready_nxt = 1'b1;
      end
      if (w_go_idle) begin
         w_state_nxt   = ST_IDLE;
         w_half_nxt    = 1'b0;
         w_ser_out_nxt = 1'b0;
      end
   end

   // State, position counters and registered serial outputs.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state       <= ST_IDLE;
         r_half        <= 1'b0;
         r_bit         <= 4'd0;
         r_sync        <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_cur_bit     <= 1'b0;
         r_ser_out     <= 1'b0;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
         r_pix_ready   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // values from before this edge, independent of statement order.
         r_state       <= w_state_nxt;
         r_half        <= w_half_nxt;
         r_bit         <= w_bit_nxt;
         r_sync        <= w_sync_nxt;
         r_col         <= w_col_nxt;
         r_row         <= w_row_nxt;
         r_cur_bit     <= w_cur_bit_nxt;
         r_ser_out     <= w_ser_out_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_line_start  <= w_line_start_nxt;
         r_pix_ready   <= w_pix_ready_nxt;
      end
   end

   // Pixel shift register: loaded at the end of the PIX_READY cycle (zero on
   // underrun), then shifted MSB-first as each data bit begins.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_shift <= '0;
      end else if (r_pix_ready) begin
         r_shift <= PIX_VALID ? PIX_DATA : '0;
      end else if (w_shift_step) begin
         r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
      end
   end

   assign PIX_READY   = r_pix_ready;
   assign UNDERRUN    = r_pix_ready & ~PIX_VALID;
   assign SER_OUT     = r_ser_out;
   assign FRAME_START = r_frame_start;
   assign LINE_START  = r_line_start;
   assign BUSY        = (r_state != ST_IDLE);
   assign SER_OUT_EN  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_naneye_tx_encoder.sv
// Directed bench for naneye_tx_encoder with ROWS=2, COLS=3, HALF_BIT_DIV=1,
// FSYNC_BITS=4, LSYNC_BITS=2 (frame = 160 cycles, line = 76 cycles).
module tb_naneye_tx_encoder;

   logic       CLOCK = 1'b0;
   logic       RESET_N;
   logic       ENABLE;
   logic [9:0] PIX_DATA;
   logic       PIX_VALID;
   logic       PIX_READY;
   logic       SER_OUT;
   logic       SER_OUT_EN;
   logic       FRAME_START;
   logic       LINE_START;
   logic       UNDERRUN;
   logic       BUSY;

   int n_checks = 0;
   int n_fail   = 0;

   // Sample vector bits: 6 SER_OUT, 5 SER_OUT_EN, 4 FRAME_START,
   // 3 LINE_START, 2 PIX_READY, 1 UNDERRUN, 0 BUSY.
   logic [6:0] s_out [0:399];
   logic [9:0] pix_tbl [0:7] = '{10'h2A5, 10'h000, 10'h3FF, 10'h155,
                                 10'h0F0, 10'h30C, 10'h111, 10'h222};

   naneye_tx_encoder #(
      .ROWS         (2),
      .COLS         (3),
      .HALF_BIT_DIV (1),
      .FSYNC_BITS   (4),
      .LSYNC_BITS   (2)
   ) dut (
      .CLOCK       (CLOCK),
      .RESET_N     (RESET_N),
      .ENABLE      (ENABLE),
      .PIX_DATA    (PIX_DATA),
      .PIX_VALID   (PIX_VALID),
      .PIX_READY   (PIX_READY),
      .SER_OUT     (SER_OUT),
      .SER_OUT_EN  (SER_OUT_EN),
      .FRAME_START (FRAME_START),
      .LINE_START  (LINE_START),
      .UNDERRUN    (UNDERRUN),
      .BUSY        (BUSY)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [6:0] outs();
      return {SER_OUT, SER_OUT_EN, FRAME_START, LINE_START, PIX_READY, UNDERRUN, BUSY};
   endfunction

   task automatic check(input string tag, input logic [35:0] observed, input logic [35:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic int count_bit(input int b, input int lo, input int hi);
      int c = 0;
      for (int i = lo; i <= hi; i++) if (s_out[i][b] === 1'b1) c++;
      return c;
   endfunction

   function automatic int first_idx(input int b, input int from, input int hi);
      for (int i = from; i <= hi; i++) if (s_out[i][b] === 1'b1) return i;
      return -1;
   endfunction

   function automatic logic [35:0] ser_bits(input int lo, input int n);
      logic [35:0] v = '0;
      for (int i = lo; i < lo + n; i++) v = {v[34:0], s_out[i][6]};
      return v;
   endfunction

   // Runs n cycles, sampling at each falling edge. ENABLE rises after sample 0
   // (so the frame starts at sample 1) and falls after sample en_off_at.
   // The load with index und_at is presented with PIX_VALID low.
   task automatic capture(input int n, input int en_off_at, input int und_at);
      int   load_idx = 0;
      logic prev_rdy = 1'b0;
      PIX_VALID = 1'b1;
      PIX_DATA  = pix_tbl[0];
      for (int i = 0; i < n; i++) begin
         @(negedge CLOCK);
         s_out[i] = outs();
         if (prev_rdy) load_idx++;
         prev_rdy  = s_out[i][2];
         PIX_VALID = (load_idx != und_at);
         PIX_DATA  = (load_idx == und_at) ? 10'h3FF : pix_tbl[load_idx[2:0]];
         if (i == 0)         ENABLE = 1'b1;
         if (i == en_off_at) ENABLE = 1'b0;
      end
   endtask

   initial begin
      RESET_N   = 1'b0;
      ENABLE    = 1'b0;
      PIX_DATA  = '0;
      PIX_VALID = 1'b0;
      #1;
      check("reset_outputs", 36'(outs()), 36'h0);
      repeat (3) @(negedge CLOCK);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLOCK);

      // Single frame, ENABLE pulsed for one cycle.
      capture(170, 1, -1);
      check("idle_before_start", 36'(s_out[0]), 36'h0);
      check("frame_start_idx",   36'(first_idx(4, 0, 169)), 36'd1);
      check("frame_start_count", 36'(count_bit(4, 0, 169)), 36'd1);
      check("busy_cycles",       36'(count_bit(0, 0, 169)), 36'd160);
      check("line_start_count",  36'(count_bit(3, 0, 169)), 36'd2);
      check("line_start_first",  36'(first_idx(3, 0, 169)), 36'd9);
      check("line_start_gap",    36'(first_idx(3, 10, 169) - first_idx(3, 0, 169)), 36'd76);
      check("pix_ready_count",   36'(count_bit(2, 0, 169)), 36'd6);
      check("pix_ready_first",   36'(first_idx(2, 0, 169)), 36'd13);
      check("underrun_none",     36'(count_bit(1, 0, 169)), 36'd0);
      check("ser_head_2a5",      ser_bits(1, 36),
            36'b11111111_0101_10_10011001100101100110_01);
      check("ser_word_000",      ser_bits(37, 24), 36'(24'b10_01010101010101010101_01));
      check("ser_word_3ff",      ser_bits(61, 24), 36'(24'b10_10101010101010101010_01));
      check("ser_line2_155",     ser_bits(85, 28), 36'(28'b0101_10_01100110011001100110_01));
      check("idle_after_frame",  36'(s_out[161]), 36'h0);

      // Underrun at the second load: zero word, frame not stretched.
      capture(170, 1, 1);
      check("underrun_count",    36'(count_bit(1, 0, 169)), 36'd1);
      check("underrun_busy",     36'(count_bit(0, 0, 169)), 36'd160);
      check("underrun_word",     ser_bits(37, 24), 36'(24'b10_01010101010101010101_01));

      // Continuous: ENABLE high through the first frame, dropped mid second.
      capture(330, 200, -1);
      check("cont_second_fs",    36'(first_idx(4, 2, 329)), 36'd161);
      check("cont_ser_en_hold",  36'(320 - count_bit(5, 1, 320)), 36'd0);
      check("cont_fsync_nogap",  36'(s_out[161][6]), 36'd1);
      check("cont_end_idle",     36'({s_out[321][5], s_out[321][0]}), 36'd0);

      // ENABLE dropped at cycle 50: frame completes, then IDLE at 161.
      capture(170, 50, -1);
      check("drop_busy_160",     36'(s_out[160][0]), 36'd1);
      check("drop_idle_161",     36'({s_out[161][5], s_out[161][0]}), 36'd0);

      // Reset at cycle 90 of a frame: outputs clear asynchronously, then a
      // fresh frame starts after release with ENABLE high.
      capture(90, -1, -1);
      check("busy_before_reset", 36'(BUSY), 36'd1);
      RESET_N = 1'b0;
      #1;
      check("async_reset_outs",  36'(outs()), 36'h0);
      repeat (2) @(negedge CLOCK);
      RESET_N = 1'b1;
      @(negedge CLOCK);
      check("restart_frame",     36'({FRAME_START, SER_OUT, SER_OUT_EN, BUSY}), 36'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/naneye_tx_encoder.md
# naneye_tx_encoder

Serial transmitter for the NanEye 2D link.
- Takes 10-bit parallel pixels from a pixel source and wraps each in the 12-bit NanEye word format.
- Manchester-encodes the words and inserts frame-sync and line-sync sequences, producing the single-wire stream that the RX decoder/deserializer chain consumes.
- Used as the sensor-side model in system benches and as the loopback source for in-FPGA link self-test.

## Interface
- `ROWS`, default 250: lines per frame.
- `COLS`, default 250: pixels per line.
- `HALF_BIT_DIV`, default 1: `CLOCK` cycles per Manchester half-bit. At 72 MHz this gives 36 Mbit/s.
- `FSYNC_BITS`, default 24: bit periods of frame sync.
- `LSYNC_BITS`, default 3: bit periods of line sync.
- `CLOCK`  in  1: single clock; every register is on its rising edge.
- `RESET_N`  in  1: reset, asynchronous and active-low.
- `ENABLE`  in  1: start and continue frames.
- `PIX_DATA`  in  10: pixel value, MSB sent first.
- `PIX_VALID`  in  1: `PIX_DATA` holds a valid pixel.
- `PIX_READY`  out  1: one-cycle pulse; `PIX_DATA` is consumed in that cycle.
- `SER_OUT`  out  1: line-level serial output.
- `SER_OUT_EN`  out  1: output driver enable; high from frame sync until the last pixel ends.
- `FRAME_START`  out  1: one-cycle pulse on the first cycle of frame sync.
- `LINE_START`  out  1: one-cycle pulse on the first cycle of each line sync.
- `UNDERRUN`  out  1: one-cycle pulse when a pixel was needed but `PIX_VALID` was low.
- `BUSY`  out  1: high in any state other than IDLE.

## Operation
- Word format, 12 bits, sent in this order: start bit `1`, then `PIX_DATA[9:0]` MSB first, then stop bit `0`.
- Manchester coding:
  - `1` is sent as half-bits `1,0`.
  - `0` is sent as half-bits `0,1`.
- Frame sync: `SER_OUT` held constant `1` for `FSYNC_BITS` bit periods. This is a deliberate code violation.
- Line sync: `LSYNC_BITS` Manchester zeros. Because there is no start bit, the receiver treats it as idle.
- States:
  - IDLE: `SER_OUT`=0, `SER_OUT_EN`=0. Goes to FSYNC when `ENABLE`=1.
  - FSYNC → LSYNC.
  - LSYNC → WORD.
  - WORD repeats `COLS` times.
  - After the last word of a line: → LSYNC if `row < ROWS-1`. Otherwise → FSYNC if `ENABLE`=1, else IDLE.
- Pixel load: `PIX_READY` pulses in the cycle the start bit begins, and the shift register loads `PIX_DATA` in that same cycle.
- Underrun: if `PIX_VALID`=0 at the load cycle, load 10'h000, pulse `UNDERRUN`, and still send the full word (start and stop bits included). The frame is never stretched.
- `ENABLE` falling mid-frame: the current frame completes. No new FSYNC starts.
- Counters:
  - Column counter width `$clog2(COLS)`, row counter width `$clog2(ROWS)`, sync-bit counter width `$clog2(max(FSYNC_BITS,LSYNC_BITS))`.
  - Each counter wraps to 0 at its terminal count. Terminal detection uses equality, never overflow.

## Timing
- Reset values: all outputs 0; state IDLE; all counters 0.
- Reset mid-frame: all outputs return to 0 asynchronously. A new frame starts only after reset is released and `ENABLE`=1.
- Bit period is `2*HALF_BIT_DIV` cycles; a word lasts `24*HALF_BIT_DIV` cycles.
- Start of frame: `ENABLE` is sampled high in IDLE at cycle t. Then at t+1:
  - `FRAME_START`=1 and `SER_OUT`=1.
  - `SER_OUT_EN`=1 and `BUSY`=1.
- Serial output is registered. Each half-bit value appears on the cycle following its tick.
- `LINE_START` coincides with the first half-bit of line sync.
- The first `PIX_READY` of a line is on the cycle after the last line-sync half-bit.
- Frame length in cycles: `2*HALF_BIT_DIV*(FSYNC_BITS + ROWS*(LSYNC_BITS + 12*COLS))`.
- Back-to-back frames: no gap cycles between the final stop bit and the next FSYNC.

## Structure
- Shared package `naneye_tx_pkg` holds:
  - the state enum;
  - word-format constants: `START_BIT`=1, `STOP_BIT`=0, `WORD_BITS`=12, `DATA_BITS`=10;
  - the Manchester half-bit mapping.
- Sub-module `naneye_tx_tick`: half-bit tick generator (down-counter reloading `HALF_BIT_DIV-1`, tick on zero). Instantiated once.

## Test plan
All scenarios use `ROWS`=2, `COLS`=3, `HALF_BIT_DIV`=1, `FSYNC_BITS`=4, `LSYNC_BITS`=2 unless stated.
- Single frame:
  - Stimulus: `ENABLE` pulsed 1 cycle, source always valid with pixels 0x2A5, 0x000, 0x3FF…
  - Required response:
    - `BUSY` high exactly 160 cycles.
    - `SER_OUT` = `11111111`, then `0101`.
    - Then first word half-bits: start `10`, data `10 01 10 01 10 01 01 10 01 10`, stop `01`.
    - 6 `PIX_READY` pulses; 2 `LINE_START` pulses, 76 cycles apart.
- Underrun: `PIX_VALID` low at the 2nd load → `UNDERRUN` pulses once; word sent as `10` + ten `01` + `01`; frame length stays 160.
- Continuous: `ENABLE` held high → the second `FRAME_START` comes exactly 160 cycles after the first; `SER_OUT_EN` never drops.
- `ENABLE` dropped at cycle 50 → the frame completes; state is IDLE and `SER_OUT_EN`=0 at cycle 161.
- Reset: `RESET_N` low at cycle 90 → all outputs 0 in the same cycle. After release with `ENABLE`=1, a fresh `FRAME_START` appears.
- Loopback: `HALF_BIT_DIV`=1 at 72 MHz into the RX decoder/deserializer; 250×250 frame of incrementing pixels → every recovered pixel matches; no `PIXEL_ERROR`.
